// File: rtl/matrix_pkg.sv
// Shared types and constants for the 5x7 LED matrix path.
// Used by the column decoders and by led_matrix_scanner.
package matrix_pkg;

    localparam int MATRIX_COLS = 5;
    localparam int MATRIX_ROWS = 7;
    localparam int FRAME_BITS  = MATRIX_COLS * MATRIX_ROWS;

    // One column bitmap; bit r drives row r.
    typedef logic [MATRIX_ROWS-1:0] column_t;

    // Packed so that bit 7*c+r of the flat frame is row r of column c.
    typedef column_t [MATRIX_COLS-1:0] frame_t;

    typedef logic [2:0] col_idx_t;

    localparam col_idx_t LAST_COL = col_idx_t'(MATRIX_COLS - 1);

    function automatic col_idx_t next_col(input col_idx_t idx);
        return (idx == LAST_COL) ? '0 : idx + col_idx_t'(1);
    endfunction

    function automatic logic [MATRIX_COLS-1:0] col_onehot(input col_idx_t idx);
        logic [MATRIX_COLS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/scan_tick_generator.sv
// Column-slot prescaler: counts 0..DIVIDER-1 and pulses tick_o on the last count.
// Ports: clk_i, rst_ni, tick_o, count_o (current slot cycle), count_next_o.
module scan_tick_generator #(
    parameter int DIVIDER = 50000,
    parameter int CW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          tick_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_next_o
);

    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o      = cnt_q;
    assign count_next_o = cnt_d;

endmodule

// File: rtl/led_matrix_scanner.sv
// 5x7 LED matrix multiplexer: one-entry shadow frame, commit at frame boundary,
// column-by-column scan. Ports: clock, reset_n, frame_data/valid/ready in,
// matrix_col/matrix_row/frame_start out. Macro MATRIX_BLANKING_EN blanks rows
// for the first BLANK_CYCLES cycles of every slot.
module led_matrix_scanner
    import matrix_pkg::*;
#(
    parameter int DIVIDER      = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [FRAME_BITS-1:0]  frame_data,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    output logic [MATRIX_COLS-1:0] matrix_col,
    output logic [MATRIX_ROWS-1:0] matrix_row,
    output logic                   frame_start
);

    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    logic          tick;
    logic [CW-1:0] slot_cnt;
    logic [CW-1:0] slot_cnt_d;

    scan_tick_generator #(
        .DIVIDER (DIVIDER),
        .CW      (CW)
    ) u_tick (
        .clk_i        (clock),
        .rst_ni       (reset_n),
        .tick_o       (tick),
        .count_o      (slot_cnt),
        .count_next_o (slot_cnt_d)
    );

    col_idx_t idx_q;
    col_idx_t idx_d;
    frame_t   disp_q;
    frame_t   disp_d;
    frame_t   shadow_q;
    frame_t   frame_in;
    logic     pending_q;

    logic [MATRIX_COLS-1:0] col_q;
    column_t                row_q;
    column_t                row_d;
    logic                   start_q;

    logic boundary;
    logic accept;
    logic commit;

    assign frame_in = frame_data;
    assign boundary = tick && (idx_q == LAST_COL);
    assign accept   = frame_valid && !pending_q;
    assign commit   = boundary && pending_q;

    // Row and column are computed from next-state values so that both
    // registers change on the same edge as the index and display buffer.
    always_comb begin
        idx_d  = tick ? next_col(idx_q) : idx_q;
        disp_d = commit ? shadow_q : disp_q;
        row_d  = disp_d[idx_d];
`ifdef MATRIX_BLANKING_EN
        if (int'(slot_cnt_d) < BLANK_CYCLES) begin
            row_d = '0;
        end
`endif
    end

`ifndef MATRIX_BLANKING_EN
    logic unused_slot;
    assign unused_slot = ^{slot_cnt_d, slot_cnt, BLANK_CYCLES[0]};
`else
    logic unused_slot;
    assign unused_slot = ^slot_cnt;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            col_q     <= col_onehot('0);
            row_q     <= '0;
            start_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            col_q   <= col_onehot(idx_d);
            row_q   <= row_d;
            start_q <= boundary;
            if (accept) begin
                shadow_q <= frame_in;
            end
            // accept and commit never coincide: commit needs pending=1.
            if (commit) begin
                pending_q <= 1'b0;
            end else if (accept) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign frame_ready = !pending_q;
    assign matrix_col  = col_q;
    assign matrix_row  = row_q;
    assign frame_start = start_q;

endmodule
